// File: rtl/cnn_frame_controller.sv
// cnn_frame_controller: streams one frame of IMAGE_WIDTH x IMAGE_HEIGHT pixels into a CNN
// pipeline, gates the CNN clock enable so no result is ever dropped, buffers results in a
// small first-word-fall-through FIFO, flushes the pipeline after the last pixel and flags
// missing (timeout) or extra results.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin a frame (honoured in IDLE or ERROR only)
//   s_data/s_valid/s_ready          input pixel stream
//   cnn_clk_en/cnn_data             CNN clock enable and pixel to the CNN
//   cnn_result/cnn_valid            CNN output
//   m_data/m_valid/m_ready/m_last   result stream to the sink, m_last marks final result
//   busy                state is FEED or FLUSH
//   done                one-cycle pulse on frame completion
//   err_count           sticky: an extra result was received
//   err_timeout         sticky: flush timed out waiting for results
module cnn_frame_controller #(
   parameter int unsigned I_WIDTH             = 8,
   parameter int unsigned CHANNELS_IN         = 3,
   parameter int unsigned O_WIDTH             = 16,
   parameter int unsigned CHANNELS_OUT        = 5,
   parameter int unsigned IMAGE_WIDTH         = 64,
   parameter int unsigned IMAGE_HEIGHT        = 32,
   parameter int unsigned TOTAL_OUTPUT_PIXELS = 1680,
   parameter int unsigned FIFO_DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES      = 200000
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [I_WIDTH*CHANNELS_IN-1:0]   s_data,
   input  logic                             s_valid,
   output logic                             s_ready,
   output logic                             cnn_clk_en,
   output logic [I_WIDTH*CHANNELS_IN-1:0]   cnn_data,
   input  logic [O_WIDTH*CHANNELS_OUT-1:0]  cnn_result,
   input  logic                             cnn_valid,
   output logic [O_WIDTH*CHANNELS_OUT-1:0]  m_data,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic                             m_last,
   output logic                             busy,
   output logic                             done,
   output logic                             err_count,
   output logic                             err_timeout
);

   localparam int unsigned PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int unsigned IN_CW  = $clog2(PIXELS + 1);
   localparam int unsigned OUT_CW = $clog2(TOTAL_OUTPUT_PIXELS + 1);
   localparam int unsigned PW     = $clog2(FIFO_DEPTH);
   localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned DW     = O_WIDTH * CHANNELS_OUT;
   localparam int unsigned IW     = I_WIDTH * CHANNELS_IN;

   typedef enum logic [2:0] {StIdle, StFeed, StFlush, StDone, StError} state_t;

   state_t              state_q, state_d;
   logic [IN_CW-1:0]    in_count_q;
   logic [OUT_CW-1:0]   out_count_q;
   logic [31:0]         timer_q;
   logic                err_count_q, err_timeout_q;

   // Each entry carries the result plus its frame-last flag in the MSB.
   logic [DW:0]         mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]       fifo_cnt_q;

   logic fifo_full, fifo_empty;
   logic accept, capture, room, push, pop, extra;
   logic last_in, timer_exp, start_ok, push_last;

   assign fifo_full  = (fifo_cnt_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (fifo_cnt_q == '0);

   // Pixel-side handshake and CNN gating; fifo_full blocks the CNN even on a same-cycle pop.
   always_comb begin
      s_ready    = 1'b0;
      cnn_clk_en = 1'b0;
      cnn_data   = '0;
      case (state_q)
         StFeed: begin
            s_ready    = !fifo_full;
            cnn_clk_en = s_valid && !fifo_full;
            cnn_data   = s_data;
         end
         StFlush: cnn_clk_en = !fifo_full;
         default: ;
      endcase
   end

   assign accept    = s_valid && s_ready;
   assign capture   = cnn_clk_en && cnn_valid;
   assign room      = (out_count_q < OUT_CW'(TOTAL_OUTPUT_PIXELS));
   assign push      = capture && room;
   assign extra     = capture && !room;
   assign pop       = m_valid && m_ready;
   assign push_last = (out_count_q == OUT_CW'(TOTAL_OUTPUT_PIXELS - 1));
   assign last_in   = (in_count_q == IN_CW'(PIXELS - 1));
   assign timer_exp = (timer_q == 32'(TIMEOUT_CYCLES - 1));
   assign start_ok  = start && ((state_q == StIdle) || (state_q == StError));

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StFeed;
         StFeed: begin
            if (extra)                 state_d = StError;
            else if (accept && last_in) state_d = StFlush;
         end
         StFlush: begin
            if (extra) state_d = StError;
            else if ((out_count_q == OUT_CW'(TOTAL_OUTPUT_PIXELS)) && fifo_empty)
               state_d = StDone;
            else if (!capture && timer_exp) state_d = StError;
         end
         StDone:  state_d = StIdle;
         StError: if (start) state_d = StFeed;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         in_count_q    <= '0;
         out_count_q   <= '0;
         timer_q       <= '0;
         err_count_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            in_count_q    <= '0;
            out_count_q   <= '0;
            timer_q       <= '0;
            err_count_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
         end else begin
            if (accept) in_count_q <= in_count_q + 1'b1;
            if (push) begin
               out_count_q <= out_count_q + 1'b1;
               wr_ptr_q    <= wr_ptr_q + 1'b1;
            end
            // Pops stay enabled in ERROR so the sink can drain results already buffered.
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
               2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
               2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
               default: ;
            endcase
            if (capture)                 timer_q <= '0;
            else if (state_q == StFlush) timer_q <= timer_q + 32'd1;
            if (extra) err_count_q <= 1'b1;
            if ((state_q == StFlush) && !capture && timer_exp) err_timeout_q <= 1'b1;
         end
      end
   end

   // Storage array needs no reset; validity is tracked by fifo_cnt_q.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {push_last, cnn_result};
   end

   assign m_valid     = !fifo_empty;
   assign m_data      = m_valid ? mem[rd_ptr_q][DW-1:0] : '0;
   assign m_last      = m_valid && mem[rd_ptr_q][DW];
   assign busy        = (state_q == StFeed) || (state_q == StFlush);
   assign done        = (state_q == StDone);
   assign err_count   = err_count_q;
   assign err_timeout = err_timeout_q;

   logic unused_iw;
   assign unused_iw = ^IW;

endmodule

// File: tb/tb_cnn_frame_controller.sv
// Directed bench for cnn_frame_controller on a 4x2 frame producing 6 results, with a
// behavioural 3-stage CNN whose result count per frame is selectable.
module tb_cnn_frame_controller;

   logic        clk = 1'b0;
   logic        reset, start, s_valid, s_ready, cnn_clk_en, cnn_valid;
   logic        m_valid, m_ready, m_last, busy, done, err_count, err_timeout;
   logic [23:0] s_data, cnn_data;
   logic [79:0] cnn_result, m_data;

   always #5 clk = ~clk;

   cnn_frame_controller #(
      .I_WIDTH(8), .CHANNELS_IN(3), .O_WIDTH(16), .CHANNELS_OUT(5),
      .IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .TOTAL_OUTPUT_PIXELS(6),
      .FIFO_DEPTH(4), .TIMEOUT_CYCLES(50)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .cnn_clk_en(cnn_clk_en), .cnn_data(cnn_data),
      .cnn_result(cnn_result), .cnn_valid(cnn_valid),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .busy(busy), .done(done), .err_count(err_count), .err_timeout(err_timeout)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   logic clr = 1'b0;
   int n_emit = 6;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural CNN: 3 enabled cycles of latency; pixel k yields a result when
   // k >= 8 - n_emit. Result r = {r at bit 40, pixel seen on cnn_data}.
   logic [2:0]  mv;
   logic [79:0] md0, md1, md2;
   int mk, mr;
   always @(posedge clk) begin
      if (reset || clr) begin
         mv <= '0; md0 <= '0; md1 <= '0; md2 <= '0; mk <= 0; mr <= 0;
      end else if (cnn_clk_en) begin
         mv[0] <= s_ready && (mk >= 8 - n_emit);
         md0   <= (80'(mr) << 40) | 80'(cnn_data);
         if (s_ready && (mk >= 8 - n_emit)) mr <= mr + 1;
         if (s_ready) mk <= mk + 1;
         mv[1] <= mv[0]; md1 <= md0;
         mv[2] <= mv[1]; md2 <= md1;
      end
   end
   assign cnn_valid  = mv[2];
   assign cnn_result = md2;

   // Monitor sampled on the falling edge.
   int acc_n, acc_first, acc_last, cap_n, cap_last, got_n, done_n, err_first, viol;
   logic [79:0] got_d [16];
   logic        got_l [16];
   always @(negedge clk) begin
      if (clr) begin
         acc_n <= 0; acc_first <= 0; acc_last <= 0; cap_n <= 0; cap_last <= 0;
         got_n <= 0; done_n <= 0; err_first <= -1; viol <= 0;
      end else begin
         if (s_valid && s_ready) begin
            if (acc_n == 0) acc_first <= cyc;
            acc_last <= cyc;
            acc_n    <= acc_n + 1;
         end
         if (cnn_clk_en && cnn_valid) begin
            cap_n    <= cap_n + 1;
            cap_last <= cyc;
         end
         if (m_valid && m_ready && got_n < 16) begin
            got_d[got_n] <= m_data;
            got_l[got_n] <= m_last;
            got_n        <= got_n + 1;
         end
         if (done) done_n <= done_n + 1;
         if (err_timeout && err_first < 0) err_first <= cyc;
         if (s_ready && ((cnn_clk_en !== s_valid) || (cnn_data !== s_data))) viol <= viol + 1;
      end
   end

   function automatic logic [79:0] exp_res(input int r, input int ne);
      logic [79:0] v;
      v = (80'(r) << 40) | 80'(24'h102030 + 24'(r + 8 - ne));
      return v;
   endfunction

   logic snap_clk_en, snap_s_ready, snap_mvalid;
   int   snap_occ;

   task automatic run_frame(input int ne, input bit gaps, input int bp, output bit ended);
      int settle;
      n_emit = ne;
      @(posedge clk); #1;
      clr = 1'b1; start = 1'b1; s_valid = 1'b0; m_ready = (bp == 0);
      @(posedge clk); #1;
      clr = 1'b0; start = 1'b0;
      ended = 1'b0; settle = 0;
      for (int c = 0; c < 400; c++) begin
         s_data  = 24'h102030 + 24'(acc_n);
         s_valid = (acc_n < 8) && (!gaps || (c % 2 == 0));
         if (bp > 0 && c == bp) begin
            snap_clk_en = cnn_clk_en; snap_s_ready = s_ready; snap_mvalid = m_valid;
            snap_occ    = cap_n - got_n;
         end
         m_ready = (c >= bp);
         @(posedge clk); #1;
         if (done_n > 0 || err_count || err_timeout) settle++;
         if (settle > 12) begin
            ended = 1'b1;
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({s_ready, cnn_clk_en, m_valid, m_last, busy, done, err_count, err_timeout} !== 8'd0) begin
         n_err++;
         $display("FAIL reset_flags: got %b required 00000000",
                  {s_ready, cnn_clk_en, m_valid, m_last, busy, done, err_count, err_timeout});
      end
      n_cmp++;
      if (cnn_data !== 24'd0) begin
         n_err++; $display("FAIL reset_cnn_data: got %h required 0", cnn_data);
      end
      n_cmp++;
      if (m_data !== 80'd0) begin
         n_err++; $display("FAIL reset_m_data: got %h required 0", m_data);
      end
   endtask

   task automatic test_nominal;
      bit ended;
      run_frame(6, 1'b0, 0, ended);
      n_cmp++;
      if (!ended) begin n_err++; $display("FAIL nom_end: got 0 required 1"); end
      n_cmp++;
      if (acc_n !== 8) begin n_err++; $display("FAIL nom_accepts: got %0d required 8", acc_n); end
      n_cmp++;
      if (acc_last - acc_first !== 7) begin
         n_err++; $display("FAIL nom_consecutive: got span %0d required 7", acc_last - acc_first);
      end
      n_cmp++;
      if (got_n !== 6) begin n_err++; $display("FAIL nom_count: got %0d required 6", got_n); end
      for (int r = 0; r < 6; r++) begin
         n_cmp++;
         if (got_d[r] !== exp_res(r, 6) || got_l[r] !== (r == 5)) begin
            n_err++;
            $display("FAIL nom_result%0d: got %h/%b required %h/%b", r, got_d[r], got_l[r],
                     exp_res(r, 6), r == 5);
         end
      end
      n_cmp++;
      if (done_n !== 1) begin n_err++; $display("FAIL nom_done: got %0d required 1", done_n); end
      n_cmp++;
      if ({err_count, err_timeout, busy} !== 3'b000) begin
         n_err++; $display("FAIL nom_flags: got %b required 000", {err_count, err_timeout, busy});
      end
      n_cmp++;
      if (viol !== 0) begin n_err++; $display("FAIL nom_gating: got %0d bad cycles required 0", viol); end
   endtask

   task automatic test_backpressure;
      bit ended;
      run_frame(6, 1'b0, 20, ended);
      n_cmp++;
      if (snap_occ !== 4 || snap_mvalid !== 1'b1) begin
         n_err++; $display("FAIL bp_fill: got %0d/%b required 4/1", snap_occ, snap_mvalid);
      end
      n_cmp++;
      if ({snap_clk_en, snap_s_ready} !== 2'b00) begin
         n_err++; $display("FAIL bp_stall: got %b required 00", {snap_clk_en, snap_s_ready});
      end
      n_cmp++;
      if (got_n !== 6 || done_n !== 1) begin
         n_err++; $display("FAIL bp_count: got %0d/%0d required 6/1", got_n, done_n);
      end
      for (int r = 0; r < 6; r++) begin
         n_cmp++;
         if (got_d[r] !== exp_res(r, 6) || got_l[r] !== (r == 5)) begin
            n_err++;
            $display("FAIL bp_result%0d: got %h/%b required %h/%b", r, got_d[r], got_l[r],
                     exp_res(r, 6), r == 5);
         end
      end
   endtask

   task automatic test_source_gaps;
      bit ended;
      run_frame(6, 1'b1, 0, ended);
      n_cmp++;
      if (acc_n !== 8 || viol !== 0) begin
         n_err++; $display("FAIL gap_accepts: got %0d/%0d required 8/0", acc_n, viol);
      end
      n_cmp++;
      if (got_n !== 6 || done_n !== 1) begin
         n_err++; $display("FAIL gap_count: got %0d/%0d required 6/1", got_n, done_n);
      end
      for (int r = 0; r < 6; r++) begin
         n_cmp++;
         if (got_d[r] !== exp_res(r, 6) || got_l[r] !== (r == 5)) begin
            n_err++;
            $display("FAIL gap_result%0d: got %h/%b required %h/%b", r, got_d[r], got_l[r],
                     exp_res(r, 6), r == 5);
         end
      end
   endtask

   task automatic test_missing_result;
      bit ended;
      run_frame(5, 1'b0, 0, ended);
      n_cmp++;
      if ({ended, err_timeout, err_count, busy} !== 4'b1100) begin
         n_err++;
         $display("FAIL miss_flags: got %b required 1100", {ended, err_timeout, err_count, busy});
      end
      n_cmp++;
      if (done_n !== 0) begin n_err++; $display("FAIL miss_done: got %0d required 0", done_n); end
      n_cmp++;
      if (err_first - cap_last !== 51) begin
         n_err++;
         $display("FAIL miss_timeout_cycle: got %0d required 51", err_first - cap_last);
      end
      n_cmp++;
      if (got_n !== 5) begin n_err++; $display("FAIL miss_count: got %0d required 5", got_n); end
      for (int r = 0; r < 5; r++) begin
         n_cmp++;
         if (got_d[r] !== exp_res(r, 5) || got_l[r] !== 1'b0) begin
            n_err++;
            $display("FAIL miss_result%0d: got %h/%b required %h/0", r, got_d[r], got_l[r],
                     exp_res(r, 5));
         end
      end
   endtask

   task automatic test_extra_result;
      bit ended;
      run_frame(7, 1'b0, 0, ended);
      n_cmp++;
      if ({ended, err_count, err_timeout, busy} !== 4'b1100) begin
         n_err++;
         $display("FAIL extra_flags: got %b required 1100", {ended, err_count, err_timeout, busy});
      end
      n_cmp++;
      if (got_n !== 6 || cap_n !== 7 || done_n !== 0) begin
         n_err++;
         $display("FAIL extra_count: got %0d/%0d/%0d required 6/7/0", got_n, cap_n, done_n);
      end
      for (int r = 0; r < 6; r++) begin
         n_cmp++;
         if (got_d[r] !== exp_res(r, 7) || got_l[r] !== (r == 5)) begin
            n_err++;
            $display("FAIL extra_result%0d: got %h/%b required %h/%b", r, got_d[r], got_l[r],
                     exp_res(r, 7), r == 5);
         end
      end
   endtask

   task automatic test_reset_mid_frame;
      bit ended;
      n_emit = 6;
      @(posedge clk); #1;
      clr = 1'b1; start = 1'b1; m_ready = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; start = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (acc_n >= 3) break;
         s_data  = 24'h102030 + 24'(acc_n);
         s_valid = 1'b1;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      n_cmp++;
      if (acc_n !== 3) begin n_err++; $display("FAIL rst_accepts: got %0d required 3", acc_n); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++;
      if ({s_ready, cnn_clk_en, m_valid, m_last, busy, done, err_count, err_timeout} !== 8'd0 ||
          m_data !== 80'd0 || cnn_data !== 24'd0) begin
         n_err++;
         $display("FAIL rst_mid_outputs: got %b required 00000000",
                  {s_ready, cnn_clk_en, m_valid, m_last, busy, done, err_count, err_timeout});
      end
      run_frame(6, 1'b0, 0, ended);
      n_cmp++;
      if (got_n !== 6 || done_n !== 1 || acc_n !== 8) begin
         n_err++;
         $display("FAIL rst_next_frame: got %0d/%0d/%0d required 6/1/8", got_n, done_n, acc_n);
      end
      for (int r = 0; r < 6; r++) begin
         n_cmp++;
         if (got_d[r] !== exp_res(r, 6) || got_l[r] !== (r == 5)) begin
            n_err++;
            $display("FAIL rst_result%0d: got %h/%b required %h/%b", r, got_d[r], got_l[r],
                     exp_res(r, 6), r == 5);
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      test_reset();
      test_nominal();
      test_backpressure();
      test_source_gaps();
      test_missing_result();
      test_extra_result();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cnn_frame_controller.md
# cnn_frame_controller

Synthesizable frame-level controller that sits between a pixel stream source, the `cnn` pipeline and a result sink. It streams exactly one frame of IMAGE_WIDTH×IMAGE_HEIGHT pixels into the CNN and gates the CNN's `clk_en` so that results are never lost. It counts results, flushes the pipeline after the last input and flags missing or extra results. It generalises the fixed 3-channel, 64×32 frame flow to parametrised channel counts, widths and frame sizes, with backpressure and error reporting.

## Interface
- I_WIDTH, 8, bits per input channel
- CHANNELS_IN, 3, input channels per pixel
- O_WIDTH, 16, bits per output channel
- CHANNELS_OUT, 5, output channels per result
- IMAGE_WIDTH, 64, pixels per row
- IMAGE_HEIGHT, 32, rows per frame
- TOTAL_OUTPUT_PIXELS, 1680, results expected per frame
- FIFO_DEPTH, 4, result FIFO entries (power of two, ≥2)
- TIMEOUT_CYCLES, 200000, maximum FLUSH cycles without a result
- clk  in  1  clock; one clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin frame (honoured in IDLE or ERROR)
- s_data  in  I_WIDTH*CHANNELS_IN  input pixel
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid&&s_ready
- cnn_clk_en  out  1  CNN clock enable
- cnn_data  out  I_WIDTH*CHANNELS_IN  pixel to CNN
- cnn_result  in  O_WIDTH*CHANNELS_OUT  CNN output
- cnn_valid  in  1  CNN output valid
- m_data  out  O_WIDTH*CHANNELS_OUT  result to sink
- m_valid  out  1  result available
- m_ready  in  1  sink accepts when m_valid&&m_ready
- m_last  out  1  m_data is final result of frame
- busy  out  1  state is FEED or FLUSH
- done  out  1  one-cycle pulse on frame completion
- err_count  out  1  sticky: extra result received
- err_timeout  out  1  sticky: flush timed out

## Operation
- States: IDLE, FEED, FLUSH, DONE, ERROR.
- IDLE: `start` clears in_count, out_count, timer and error flags, then goes to FEED.
- ERROR: only `start` (same clearing, FIFO emptied) or `reset` leaves it.
- FEED:
  - `s_ready = !fifo_full`; `cnn_clk_en = s_valid && !fifo_full`; `cnn_data = s_data`.
  - Each accepted pixel increments in_count.
  - When in_count reaches IMAGE_WIDTH*IMAGE_HEIGHT on an accept, go to FLUSH.
- FLUSH:
  - `s_ready = 0`; `cnn_data = 0`; `cnn_clk_en = !fifo_full`.
  - Timer increments each cycle with no result captured and clears on capture.
  - Timer reaching TIMEOUT_CYCLES: set err_timeout, go to ERROR.
  - out_count == TOTAL_OUTPUT_PIXELS and FIFO empty: go to DONE.
- Result capture happens on any cycle with `cnn_clk_en && cnn_valid`, in FEED or FLUSH.
  - out_count < TOTAL_OUTPUT_PIXELS: write `cnn_result` to the FIFO together with a last bit (set when out_count == TOTAL_OUTPUT_PIXELS-1), then increment out_count.
  - Otherwise: discard the result, set err_count, go to ERROR.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- FIFO:
  - fifo_full blocks `cnn_clk_en` even if a pop happens in the same cycle. The FIFO therefore never overflows.
  - Push and pop in the same cycle are both honoured.
  - Pointers wrap modulo FIFO_DEPTH.
  - Contents are retained in ERROR until start or reset.
- Counter widths: $clog2(max+1). Timer is 32 bits. No saturation is needed, because the state changes before any counter overflows.

## Timing
- Reset: state IDLE, FIFO empty. All outputs are 0: s_ready, cnn_clk_en, cnn_data, m_data, m_valid, m_last, busy, done, err_count, err_timeout.
- Reset mid-frame aborts immediately. Counters and FIFO clear on the next edge.
- s_ready, cnn_clk_en and cnn_data are combinational from state, s_valid, s_data and fifo_full. No bubble is inserted between accepted pixels.
- Result latency: a result captured at edge N is visible on m_valid/m_data after edge N (first-word fall-through, 1 cycle).
- `start` while busy is ignored.
- `start` in the DONE cycle is ignored; it must be reasserted in IDLE.
- m_last is valid only while m_valid is high.
- done is asserted in the cycle after the last result is popped and FIFO is empty.
- Throughput: 1 pixel per cycle whenever s_valid=1 and m_ready is held high.

## Test plan
- Nominal frame: IMAGE_WIDTH=4, IMAGE_HEIGHT=2, TOTAL_OUTPUT_PIXELS=6, behavioural CNN with 3-cycle latency, s_valid and m_ready held high -> 8 accepts on consecutive cycles; 6 results in order, m_last on the 6th only; done pulses once; no error flags set.
- Sink backpressure: same frame, m_ready=0 for 20 cycles -> FIFO fills to 4 entries; cnn_clk_en and s_ready drop to 0; no result is lost or duplicated; order is preserved after m_ready returns.
- Source gaps: s_valid toggles every other cycle -> cnn_clk_en follows s_valid; in_count reaches 8; results are identical to the nominal frame.
- Missing result: CNN model emits 5 of 6 results, TIMEOUT_CYCLES=50 -> err_timeout=1 after 50 idle FLUSH cycles; state is ERROR; done is never pulsed.
- Extra result: CNN model emits 7 results -> the 7th is discarded; err_count=1; m_valid delivers exactly 6 results.
- Reset mid-frame: assert reset after 3 accepted pixels, then issue start -> all outputs read 0 after reset; the next frame completes normally with 6 results.
